// File: rtl/cla_pkg.sv
// Shared types and helpers for the carry-lookahead propagate/generate stage.
package cla_pkg;

    localparam int CLA_GROUP_W = 4;

    // One lookahead group's contribution to the registered beat; cout feeds the next group.
    typedef struct packed {
        logic [CLA_GROUP_W-1:0] p;
        logic [CLA_GROUP_W-1:0] c;
        logic                   cout;
    } cla_beat_t;

    // Returns {Pg, Gg} for one 4-bit group.
    function automatic logic [1:0] cla_group_pg(input logic [CLA_GROUP_W-1:0] p,
                                                input logic [CLA_GROUP_W-1:0] g);
        logic pg;
        logic gg;
        pg = &p;
        gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        return {pg, gg};
    endfunction

endpackage

// File: rtl/cla4_lookahead.sv
// Combinational 4-bit lookahead group: in-group carries plus group carry-out.
module cla4_lookahead
    import cla_pkg::*;
(
    input  logic [CLA_GROUP_W-1:0] p_i,
    input  logic [CLA_GROUP_W-1:0] g_i,
    input  logic                   cin_i,
    output cla_beat_t              beat_o
);

    logic [1:0] pgGg;

    assign pgGg = cla_group_pg(p_i, g_i);

    // Flat two-level lookahead form for every carry inside the group.
    always_comb begin
        beat_o      = '0;
        beat_o.p    = p_i;
        beat_o.c[0] = cin_i;
        beat_o.c[1] = g_i[0] | (p_i[0] & cin_i);
        beat_o.c[2] = g_i[1] | (p_i[1] & g_i[0]) | (p_i[1] & p_i[0] & cin_i);
        beat_o.c[3] = g_i[2] | (p_i[2] & g_i[1]) | (p_i[2] & p_i[1] & g_i[0])
                    | (p_i[2] & p_i[1] & p_i[0] & cin_i);
        beat_o.cout = pgGg[0] | (pgGg[1] & cin_i);
    end

endmodule

// File: rtl/cla_pg_carry_stage.sv
// Two-stage valid/ready pipeline producing propagate bits and lookahead carries for the sum stage.
// Optional signed-overflow output is enabled with `define CLA_OVF_EN.
module cla_pg_carry_stage
    import cla_pkg::*;
#(
    parameter  int NGROUPS = 1,
    localparam int WIDTH   = CLA_GROUP_W * NGROUPS
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] p_out,
    output logic [WIDTH-1:0] c_out,
    output logic             cout
`ifdef CLA_OVF_EN
    ,
    output logic             ovf
`endif
);

    logic             s1_valid_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             cin_q;

    logic             s2_valid_q;
    logic [WIDTH-1:0] p_q;
    logic [WIDTH-1:0] c_q;
    logic             cout_q;

    logic [WIDTH-1:0] p_d;
    logic [WIDTH-1:0] c_d;
    logic             cout_d;
    logic [WIDTH-1:0] g_s1;
    logic [NGROUPS:0] cg;
    cla_beat_t        grp [NGROUPS];

    logic adv1;
    logic adv2;

    assign adv2     = !s2_valid_q || out_ready;
    assign adv1     = !s1_valid_q || adv2;
    assign in_ready = adv1;

    assign g_s1  = a_q & b_q;
    assign cg[0] = cin_q;

    // Groups ripple their carry-out into the next group's carry-in.
    for (genvar k = 0; k < NGROUPS; k++) begin : g_group
        cla4_lookahead u_la (
            .p_i    (a_q[CLA_GROUP_W*k +: CLA_GROUP_W] ^ b_q[CLA_GROUP_W*k +: CLA_GROUP_W]),
            .g_i    (g_s1[CLA_GROUP_W*k +: CLA_GROUP_W]),
            .cin_i  (cg[k]),
            .beat_o (grp[k])
        );
        assign cg[k+1]                          = grp[k].cout;
        assign p_d[CLA_GROUP_W*k +: CLA_GROUP_W] = grp[k].p;
        assign c_d[CLA_GROUP_W*k +: CLA_GROUP_W] = grp[k].c;
    end

    assign cout_d = cg[NGROUPS];

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            cin_q      <= 1'b0;
            s2_valid_q <= 1'b0;
            p_q        <= '0;
            c_q        <= '0;
            cout_q     <= 1'b0;
        end else begin
            if (adv1) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    a_q   <= a;
                    b_q   <= b;
                    cin_q <= cin;
                end
            end
            if (adv2) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    p_q    <= p_d;
                    c_q    <= c_d;
                    cout_q <= cout_d;
                end
            end
        end
    end

`ifdef CLA_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (adv2 && s1_valid_q) begin
            ovf_q <= c_d[WIDTH-1] ^ cout_d;
        end
    end

    assign ovf = ovf_q;
`endif

    assign out_valid = s2_valid_q;
    assign p_out     = p_q;
    assign c_out     = c_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_cla_pg_carry_stage.sv
// Scoreboard bench for cla_pg_carry_stage: a 1-group and a 2-group instance side by side.
module tb_cla_pg_carry_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;

    logic       inValid1, inReady1, cin1, outValid1, outReady1, cout1;
    logic [3:0] a1, b1, pOut1, cOut1;
    logic       inValid2, inReady2, cin2, outValid2, outReady2, cout2;
    logic [7:0] a2, b2, pOut2, cOut2;
`ifdef CLA_OVF_EN
    logic       ovf1, ovf2;
`endif

    cla_pg_carry_stage #(.NGROUPS(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(inValid1), .in_ready(inReady1),
        .a(a1), .b(b1), .cin(cin1), .out_valid(outValid1), .out_ready(outReady1),
        .p_out(pOut1), .c_out(cOut1), .cout(cout1)
`ifdef CLA_OVF_EN
        , .ovf(ovf1)
`endif
    );

    cla_pg_carry_stage #(.NGROUPS(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(inValid2), .in_ready(inReady2),
        .a(a2), .b(b2), .cin(cin2), .out_valid(outValid2), .out_ready(outReady2),
        .p_out(pOut2), .c_out(cOut2), .cout(cout2)
`ifdef CLA_OVF_EN
        , .ovf(ovf2)
`endif
    );

    typedef struct {
        logic [7:0] p;
        logic [7:0] c;
        logic       cout;
        logic       ovf;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    int   tests = 0;
    int   fails = 0;
    int   pops2 = 0;

    // Reference: carries recovered from the true sum, c[i] = s[i] ^ p[i].
    function automatic exp_t model(input int w, input logic [7:0] a, input logic [7:0] b,
                                   input logic cin);
        exp_t       e;
        logic [8:0] s;
        if (w == 4) begin
            s      = {5'b0, a[3:0]} + {5'b0, b[3:0]} + {8'b0, cin};
            e.p    = {4'h0, a[3:0] ^ b[3:0]};
            e.c    = {4'h0, s[3:0] ^ e.p[3:0]};
            e.cout = s[4];
            e.ovf  = e.c[3] ^ e.cout;
        end else begin
            s      = {1'b0, a} + {1'b0, b} + {8'b0, cin};
            e.p    = a ^ b;
            e.c    = s[7:0] ^ e.p;
            e.cout = s[8];
            e.ovf  = e.c[7] ^ e.cout;
        end
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: record accepted beats, compare consumed beats, then move past the edge.
    task automatic applyStimulus();
        exp_t e;
        @(negedge clk);
        if (rst) begin
            q1.delete();
            q2.delete();
        end else begin
            if (inValid1 && inReady1) q1.push_back(model(4, {4'h0, a1}, {4'h0, b1}, cin1));
            if (inValid2 && inReady2) q2.push_back(model(8, a2, b2, cin2));
            if (outValid1 && outReady1) begin
                if (q1.size() == 0) begin
                    checkOutput("dut1_spurious_beat", {63'b0, outValid1}, 64'd0);
                end else begin
                    e = q1.pop_front();
                    checkOutput("dut1_p", pOut1, e.p[3:0]);
                    checkOutput("dut1_c", cOut1, e.c[3:0]);
                    checkOutput("dut1_cout", cout1, e.cout);
`ifdef CLA_OVF_EN
                    checkOutput("dut1_ovf", ovf1, e.ovf);
`endif
                end
            end
            if (outValid2 && outReady2) begin
                if (q2.size() == 0) begin
                    checkOutput("dut2_spurious_beat", {63'b0, outValid2}, 64'd0);
                end else begin
                    e = q2.pop_front();
                    pops2++;
                    checkOutput("dut2_p", pOut2, e.p);
                    checkOutput("dut2_c", cOut2, e.c);
                    checkOutput("dut2_cout", cout2, e.cout);
`ifdef CLA_OVF_EN
                    checkOutput("dut2_ovf", ovf2, e.ovf);
`endif
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] bpA [5];
        logic [3:0] bpB [5];
        logic       bpCin [5];
        logic [3:0] heldP, heldC;
        logic       acc;
        int         idx;

        bpA   = '{4'h1, 4'h2, 4'h4, 4'h8, 4'hF};
        bpB   = '{4'h2, 4'h4, 4'h1, 4'h6, 4'h3};
        bpCin = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        // Reset held two cycles with a beat offered.
        rst       = 1'b1;
        inValid1  = 1'b1; a1 = 4'h5; b1 = 4'h3; cin1 = 1'b1; outReady1 = 1'b1;
        inValid2  = 1'b1; a2 = 8'h5A; b2 = 8'hC3; cin2 = 1'b1; outReady2 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        inValid1 = 1'b0;
        inValid2 = 1'b0;
        checkOutput("rst_out_valid1", outValid1, 0);
        checkOutput("rst_p_out1", pOut1, 0);
        checkOutput("rst_c_out1", cOut1, 0);
        checkOutput("rst_cout1", cout1, 0);
        checkOutput("rst_out_valid2", outValid2, 0);
        checkOutput("rst_p_out2", pOut2, 0);
        checkOutput("rst_c_out2", cOut2, 0);
        checkOutput("rst_cout2", cout2, 0);
`ifdef CLA_OVF_EN
        checkOutput("rst_ovf1", ovf1, 0);
`endif
        repeat (4) begin
            checkOutput("rst_no_beat1", outValid1, 0);
            checkOutput("rst_no_beat2", outValid2, 0);
            applyStimulus();
        end

        // Single beat with two-cycle latency.
        inValid1 = 1'b1; a1 = 4'h7; b1 = 4'h9; cin1 = 1'b0;
        checkOutput("single_in_ready", inReady1, 1);
        applyStimulus();
        inValid1 = 1'b0;
        checkOutput("single_lat_n1", outValid1, 0);
        applyStimulus();
        checkOutput("single_lat_n2", outValid1, 1);
        checkOutput("single_p", pOut1, 4'hE);
        checkOutput("single_c", cOut1, 4'hE);
        checkOutput("single_cout", cout1, 1);
`ifdef CLA_OVF_EN
        checkOutput("single_ovf", ovf1, 0);
`endif
        applyStimulus();

        // Signed overflow case.
        inValid1 = 1'b1; a1 = 4'h7; b1 = 4'h1; cin1 = 1'b0;
        applyStimulus();
        inValid1 = 1'b0;
        applyStimulus();
        checkOutput("ovf_case_valid", outValid1, 1);
        checkOutput("ovf_case_p", pOut1, 4'h6);
        checkOutput("ovf_case_c", cOut1, 4'hE);
        checkOutput("ovf_case_cout", cout1, 0);
`ifdef CLA_OVF_EN
        checkOutput("ovf_case_ovf", ovf1, 1);
`endif
        applyStimulus();

        // Five beats with the sink stalled in cycles 3..6.
        idx = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            outReady1 = !(cyc >= 3 && cyc <= 6);
            inValid1  = (idx < 5);
            a1        = (idx < 5) ? bpA[idx] : 4'h0;
            b1        = (idx < 5) ? bpB[idx] : 4'h0;
            cin1      = (idx < 5) ? bpCin[idx] : 1'b0;
            #1;
            acc = inValid1 && inReady1;
            if (cyc == 3) begin
                heldP = pOut1;
                heldC = cOut1;
                checkOutput("bp_valid_at_stall", outValid1, 1);
            end
            if (cyc >= 4 && cyc <= 6) begin
                checkOutput("bp_in_ready_full", inReady1, 0);
                checkOutput("bp_hold_p", pOut1, heldP);
                checkOutput("bp_hold_c", cOut1, heldC);
                checkOutput("bp_hold_valid", outValid1, 1);
            end
            applyStimulus();
            if (acc) idx++;
        end
        inValid1 = 1'b0;
        checkOutput("bp_all_accepted", idx, 5);
        checkOutput("bp_all_delivered", q1.size(), 0);

        // Full rate on the two-group instance.
        outReady2 = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            inValid2 = 1'b1;
            a2       = 8'($urandom);
            b2       = 8'($urandom);
            cin2     = 1'($urandom);
            #1;
            checkOutput("fr_in_ready", inReady2, 1);
            applyStimulus();
        end
        a2 = 8'hFF; b2 = 8'h00; cin2 = 1'b1;
        applyStimulus();
        inValid2 = 1'b0;
        applyStimulus();
        checkOutput("fr_ff_valid", outValid2, 1);
        checkOutput("fr_ff_p", pOut2, 8'hFF);
        checkOutput("fr_ff_c", cOut2, 8'hFF);
        checkOutput("fr_ff_cout", cout2, 1);
        applyStimulus();
        checkOutput("fr_beat_count", pops2, 1001);
        checkOutput("fr_drained", q2.size(), 0);

        // Reset with two beats in flight.
        outReady1 = 1'b0;
        inValid1  = 1'b1; a1 = 4'h3; b1 = 4'h5; cin1 = 1'b0;
        applyStimulus();
        a1 = 4'h6; b1 = 4'h6; cin1 = 1'b1;
        applyStimulus();
        inValid1 = 1'b0;
        checkOutput("mr_pipe_loaded", outValid1, 1);
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        checkOutput("mr_out_valid_next", outValid1, 0);
        outReady1 = 1'b1;
        repeat (5) begin
            checkOutput("mr_no_emit", outValid1, 0);
            applyStimulus();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
